fetch_unit: RTL

Instruction fetch stage for the 16-bit CPU. It holds the program counter (PC), issues read requests to instruction memory, and captures each returned word in a one-entry instruction register (IR). The IR feeds decode, which drives the A/D register loads. Handles stalls from both sides, jump redirects and halt.

---
 rtl/fetch_unit.sv | 118 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: program counter, instruction-memory request/handshake and a one-entry IR for decode.
// Optional build macro FETCH_PERF_EN adds saturating fetch_count/stall_count outputs.
module fetch_unit #(
    parameter int unsigned       ADDR_W       = 15,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [15:0]       imem_rdata,
    output logic              instr_valid,
    output logic [15:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              halt,
    output logic [ADDR_W-1:0] pc
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]       fetch_count,
    output logic [15:0]       stall_count
`endif
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        WAIT,
        HALTED
    } state_t;

    localparam logic [ADDR_W-1:0] PC_STEP = 1;

    state_t state;
    logic   ir_room;
    logic   handshake;
    logic   consume;

    assign imem_addr = pc;
    assign ir_room   = !instr_valid || instr_ready;
    assign handshake = imem_req && imem_ready;
    assign consume   = instr_valid && instr_ready;

    // The request must react to jump/halt in the same cycle, so it cannot be registered.
    // NOTE: every branch below assigns imem_req via the default first, so no latch is inferred.
    always_comb begin
        imem_req = 1'b0;
        if (!reset && !jump) begin
            case (state)
                RUN:     imem_req = !halt && ir_room;
                WAIT:    imem_req = 1'b1;
                default: imem_req = 1'b0;
            endcase
        end
    end

    // NOTE: state and datapath registers use non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= BOOT;
            pc          <= RESET_VECTOR;
            instr_valid <= 1'b0;
            instr       <= 16'h0000;
            instr_pc    <= '0;
        end else if (jump) begin
            // Flush only the valid bit; the stale IR word and its address stay visible.
            pc          <= jump_addr;
            instr_valid <= 1'b0;
            state       <= halt ? HALTED : RUN;
        end else begin
            if (handshake) begin
                instr       <= imem_rdata;
                instr_pc    <= pc;
                instr_valid <= 1'b1;
                pc          <= pc + PC_STEP;
            end else if (consume) begin
                instr_valid <= 1'b0;
            end

            case (state)
                BOOT: state <= RUN;
                RUN: begin
                    if (halt)
                        state <= HALTED;
                    else if (imem_req && !imem_ready)
                        state <= WAIT;
                end
                WAIT: begin
                    if (imem_ready)
                        state <= RUN;
                end
                HALTED: begin
                    if (!halt)
                        state <= RUN;
                end
                default: state <= BOOT;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count <= 16'h0000;
            stall_count <= 16'h0000;
        end else begin
            if (handshake && fetch_count != 16'hFFFF)
                fetch_count <= fetch_count + 16'd1;
            if (state == WAIT && stall_count != 16'hFFFF)
                stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule
